argmax_feeder: RTL and testbench

//  Transmit side of the CAF argmax stream. Buffers one frame of buffer_length complex I/Q samples from a write port.
//  On start, plays the frame out over the xi/xq valid/ready stream, then holds result-ready and captures (out_max, index).

---
 rtl/caf_pkg.sv | 31 +++
 rtl/argmax_feeder_sample_buffer.sv | 25 ++
 rtl/argmax_feeder.sv | 169 ++++++++++++++++
 tb/tb_argmax_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caf_pkg.sv
// Shared definitions for the CAF argmax stream: FSM encodings, default widths
// (kept in step with the argmax block) and a constant-width helper.
package caf_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    localparam int DEF_BUFFER_LENGTH  = 10;
    localparam int DEF_INDEX_BITS     = 4;
    localparam int DEF_OUT_MAX_BITS   = 4;
    localparam int DEF_I_BITS         = 12;
    localparam int DEF_Q_BITS         = 12;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Number of bits needed to address 'value' distinct items.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_feeder_sample_buffer.sv
// Frame storage for argmax_feeder: depth x width register file with one write
// port and one registered read port. Contents are never reset.
module sample_buffer #(
    parameter int depth     = 10,
    parameter int addr_bits = 4,
    parameter int width     = 24
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [width-1:0]     wr_data,
    input  logic [addr_bits-1:0] rd_addr,
    output logic [width-1:0]     rd_data
);

    logic [width-1:0] mem_reg [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        rd_data <= mem_reg[rd_addr];
    end

endmodule

// File: rtl/argmax_feeder.sv
// Transmit side of the CAF argmax stream: fill a frame, play it out over xi/xq,
// then capture the argmax result. Optional watchdog: ARGMAX_FEEDER_TIMEOUT_EN.
module argmax_feeder
    import caf_pkg::*;
#(
    parameter int buffer_length  = DEF_BUFFER_LENGTH,
    parameter int index_bits     = DEF_INDEX_BITS,
    parameter int out_max_bits   = DEF_OUT_MAX_BITS,
    parameter int i_bits         = DEF_I_BITS,
    parameter int q_bits         = DEF_Q_BITS,
    parameter int timeout_cycles = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [i_bits-1:0]       wr_i,
    input  logic [q_bits-1:0]       wr_q,
    output logic                    wr_full,
    input  logic                    start,
    output logic                    busy,
    output logic                    m_axis_tvalid,
    output logic [i_bits-1:0]       xi,
    output logic [q_bits-1:0]       xq,
    input  logic                    s_axis_tready,
    output logic                    m_axis_tready,
    input  logic [out_max_bits-1:0] out_max,
    input  logic [index_bits-1:0]   index,
    input  logic                    s_axis_tvalid,
    output logic [out_max_bits-1:0] result_max,
    output logic [index_bits-1:0]   result_index,
    output logic                    done,
    output logic                    timeout_err
);

    localparam int                  sample_bits = i_bits + q_bits;
    localparam logic [index_bits:0] full_count  = (index_bits+1)'(buffer_length);
    localparam logic [index_bits:0] last_ptr    = (index_bits+1)'(buffer_length - 1);
    localparam logic [index_bits:0] ptr_one     = (index_bits+1)'(1);

    state_t                  state_reg;
    logic [index_bits:0]     wr_count_reg;
    logic [index_bits:0]     rd_ptr_reg;
    logic [index_bits:0]     rd_ptr_next;
    logic                    valid_reg;
    logic                    tready_reg;
    logic                    done_reg;
    logic [out_max_bits-1:0] result_max_reg;
    logic [index_bits-1:0]   result_index_reg;
    logic [index_bits-1:0]   rd_addr;
    logic [sample_bits-1:0]  rd_data;
    logic                    wr_accept;
    logic                    transfer;
    logic                    timeout_hit;

    assign wr_full     = (wr_count_reg == full_count);
    assign wr_accept   = (state_reg == IDLE) && wr_en && !wr_full;
    assign transfer    = (state_reg == STREAM) && valid_reg && s_axis_tready;
    assign rd_ptr_next = rd_ptr_reg + ptr_one;

    // Prefetch the next sample on a transfer so the following beat has no bubble;
    // otherwise re-read the current slot, which keeps xi/xq stable under stall.
    always_comb begin
        rd_addr = rd_ptr_reg[index_bits-1:0];
        if (transfer && (rd_ptr_reg != last_ptr)) begin
            rd_addr = rd_ptr_next[index_bits-1:0];
        end
    end

    sample_buffer #(
        .depth     (buffer_length),
        .addr_bits (index_bits),
        .width     (sample_bits)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_count_reg[index_bits-1:0]),
        .wr_data ({wr_i, wr_q}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wr_count_reg     <= '0;
            rd_ptr_reg       <= '0;
            valid_reg        <= 1'b0;
            tready_reg       <= 1'b0;
            done_reg         <= 1'b0;
            result_max_reg   <= '0;
            result_index_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_accept) begin
                        wr_count_reg <= wr_count_reg + ptr_one;
                    end
                    if (start && wr_full) begin
                        state_reg  <= STREAM;
                        rd_ptr_reg <= '0;
                        valid_reg  <= 1'b1;
                        tready_reg <= 1'b1;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        rd_ptr_reg <= rd_ptr_next;
                        if (rd_ptr_reg == last_ptr) begin
                            state_reg <= WAIT_RES;
                            valid_reg <= 1'b0;
                        end
                    end
                end
                WAIT_RES: begin
                    if (s_axis_tvalid) begin
                        result_max_reg   <= out_max;
                        result_index_reg <= index;
                        done_reg         <= 1'b1;
                    end
                    if (s_axis_tvalid || timeout_hit) begin
                        state_reg    <= IDLE;
                        wr_count_reg <= '0;
                        rd_ptr_reg   <= '0;
                        tready_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ARGMAX_FEEDER_TIMEOUT_EN
    localparam int               tmo_bits = clog2(timeout_cycles + 1);
    localparam logic [tmo_bits-1:0] tmo_last = tmo_bits'(timeout_cycles - 1);
    localparam logic [tmo_bits-1:0] tmo_one  = tmo_bits'(1);

    logic [tmo_bits-1:0] tmo_count_reg;
    logic                timeout_reg;

    assign timeout_hit = (state_reg == WAIT_RES) && !s_axis_tvalid && (tmo_count_reg == tmo_last);

    always_ff @(posedge clk) begin
        if (rst || (state_reg != WAIT_RES)) begin
            tmo_count_reg <= '0;
        end else if (!s_axis_tvalid) begin
            tmo_count_reg <= tmo_count_reg + tmo_one;
        end
        timeout_reg <= !rst && timeout_hit;
    end

    assign timeout_err = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy          = (state_reg != IDLE);
    assign m_axis_tvalid = valid_reg;
    assign m_axis_tready = tready_reg;
    assign xi            = valid_reg ? rd_data[sample_bits-1:q_bits] : '0;
    assign xq            = valid_reg ? rd_data[q_bits-1:0] : '0;
    assign result_max    = result_max_reg;
    assign result_index  = result_index_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_argmax_feeder.sv
// Self-checking bench for argmax_feeder; the argmax block is stood in for by an
// L1-magnitude peak search over the beats actually received.
module tb_argmax_feeder;

    localparam int N  = 10;
    localparam int IB = 4;
    localparam int OB = 4;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          start = 1'b0;
    logic          s_axis_tready = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [W-1:0]  wr_i = '0;
    logic [W-1:0]  wr_q = '0;
    logic [OB-1:0] out_max = '0;
    logic [IB-1:0] index = '0;
    logic [W-1:0]  xi, xq;
    logic [OB-1:0] result_max;
    logic [IB-1:0] result_index;
    logic          wr_full, busy, m_axis_tvalid, m_axis_tready, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    logic [W-1:0] model_i[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] beat_i[$];
    logic [W-1:0] beat_q[$];

    argmax_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_i          (wr_i),
        .wr_q          (wr_q),
        .wr_full       (wr_full),
        .start         (start),
        .busy          (busy),
        .m_axis_tvalid (m_axis_tvalid),
        .xi            (xi),
        .xq            (xq),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .out_max       (out_max),
        .index         (index),
        .s_axis_tvalid (s_axis_tvalid),
        .result_max    (result_max),
        .result_index  (result_index),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int l1(input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        int y;
        x = int'($signed(a));
        y = int'($signed(b));
        return (x < 0 ? -x : x) + (y < 0 ? -y : y);
    endfunction

    // Peak {saturated magnitude, first index of maximum} of the written frame or of the received beats.
    function automatic logic [7:0] peak_of(input bit from_beats);
        int best;
        int bi;
        int m;
        int n;
        best = -1;
        bi   = 0;
        n    = from_beats ? beat_i.size() : model_i.size();
        for (int k = 0; k < n; k++) begin
            m = from_beats ? l1(beat_i[k], beat_q[k]) : l1(model_i[k], model_q[k]);
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
        return {OB'(best > 15 ? 15 : best), IB'(bi)};
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_wr_full"}, wr_full, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_xi"}, xi, 0);
        chk({tag, "_xq"}, xq, 0);
        chk({tag, "_tready"}, m_axis_tready, 0);
        chk({tag, "_rmax"}, result_max, 0);
        chk({tag, "_ridx"}, result_index, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    task automatic clear_model();
        model_i.delete();
        model_q.delete();
        beat_i.delete();
        beat_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("rst");
        rst = 1'b0;
        clear_model();
    endtask

    task automatic write_sample(input logic [W-1:0] i, input logic [W-1:0] q);
        wr_en = 1'b1;
        wr_i  = i;
        wr_q  = q;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (model_i.size() < N) begin
            model_i.push_back(i);
            model_q.push_back(q);
        end
        chk("wr_full", wr_full, (model_i.size() == N) ? 1 : 0);
    endtask

    task automatic write_random(input int count);
        for (int k = 0; k < count; k++) begin
            write_sample(W'($urandom), W'($urandom));
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives the downstream ready, checks every beat against the written frame.
    task automatic play(input bit toggle, input bit disturb, input int abort_at, output bit aborted);
        int k;
        int cyc;
        bit stalled;
        bit rdy;
        logic [W-1:0] held_i, held_q;
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        held_i = '0;
        held_q = '0;
        aborted = 1'b0;
        while (k < N && cyc < 4 * N) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            s_axis_tready = rdy;
            if (disturb) begin
                start = 1'b1;
                wr_en = 1'b1;
                wr_i = W'($urandom);
                wr_q = W'($urandom);
                s_axis_tvalid = 1'b1;
                out_max = OB'($urandom);
                index = IB'($urandom);
            end
            chk("stream_valid", m_axis_tvalid, 1);
            chk("stream_tready", m_axis_tready, 1);
            chk("stream_busy", busy, 1);
            if (stalled) begin
                chk("stall_xi", xi, held_i);
                chk("stall_xq", xq, held_q);
            end
            if (rdy) begin
                chk("beat_xi", xi, model_i[k]);
                chk("beat_xq", xq, model_q[k]);
                beat_i.push_back(xi);
                beat_q.push_back(xq);
                k++;
                if (k == abort_at) rst = 1'b1;
            end
            stalled = !rdy;
            held_i = xi;
            held_q = xq;
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                start = 1'b0;
                wr_en = 1'b0;
                s_axis_tvalid = 1'b0;
                aborted = 1'b1;
                return;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'($urandom_range(0, 1));
        chk("beat_count", k, N);
        chk("beat_cycles", cyc, toggle ? 2 * N - 1 : N);
        chk("tail_valid", m_axis_tvalid, 0);
        chk("tail_xi", xi, 0);
        chk("tail_busy", busy, 1);
        chk("tail_tready", m_axis_tready, 1);
    endtask

    // The stand-in argmax answers after 'delay' idle cycles with its peak of the received beats.
    task automatic respond(input int delay);
        logic [7:0] exp_pk;
        logic [7:0] got_pk;
        exp_pk = peak_of(1'b0);
        got_pk = peak_of(1'b1);
        for (int d = 0; d < delay; d++) begin
            chk("wait_tready", m_axis_tready, 1);
            chk("wait_done", done, 0);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1;
        out_max = got_pk[7:4];
        index = got_pk[3:0];
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        out_max = OB'($urandom);
        index = IB'($urandom);
        chk("res_done", done, 1);
        chk("res_max", result_max, exp_pk[7:4]);
        chk("res_index", result_index, exp_pk[3:0]);
        chk("res_busy", busy, 0);
        chk("res_tready", m_axis_tready, 0);
        chk("res_wr_full", wr_full, 0);
        @(posedge clk); #1;
        chk("res_done_clear", done, 0);
        chk("res_max_hold", result_max, exp_pk[7:4]);
        chk("res_index_hold", result_index, exp_pk[3:0]);
        frame_no++;
        $display("frame %0d: %0d beats, result_max=%0d result_index=%0d", frame_no, beat_i.size(), result_max, result_index);
        clear_model();
    endtask

    initial begin
        bit ab;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // 1: ramp frame, ready always high
        for (int k = 0; k < N; k++) write_sample(W'(k), '0);
        start_pulse();
        play(1'b0, 1'b0, 0, ab);
        respond(0);
        chk("t1_index", result_index, 9);

        // 2: same frame with ready toggling
        for (int k = 0; k < N; k++) write_sample(W'(k), '0);
        start_pulse();
        play(1'b1, 1'b0, 0, ab);
        respond(2);
        chk("t2_index", result_index, 9);

        // 3: overfill, then short-frame start and the one-short write+start race
        write_random(N + 1);
        chk("t3_full", wr_full, 1);
        start_pulse();
        play(1'b0, 1'b0, 0, ab);
        respond(1);
        reset_dut();
        write_random(N - 1);
        start_pulse();
        chk("t3_short_busy", busy, 0);
        chk("t3_short_valid", m_axis_tvalid, 0);
        start = 1'b1;
        write_sample(W'($urandom), W'($urandom));
        start = 1'b0;
        chk("t3_race_busy", busy, 0);
        @(posedge clk); #1;
        chk("t3_race_valid", m_axis_tvalid, 0);
        start_pulse();
        play(1'b0, 1'b0, 0, ab);
        respond(0);

        // 4: reset on the 5th transfer, then a clean frame
        write_random(N);
        start_pulse();
        play(1'b0, 1'b0, 5, ab);
        chk("t4_aborted", ab, 1);
        check_zero("t4_abort");
        rst = 1'b0;
        clear_model();
        write_random(N);
        start_pulse();
        play(1'b1, 1'b0, 0, ab);
        respond(1);

        // 5: start, wr_en and result-valid noise while streaming
        write_random(N);
        start_pulse();
        play(1'b1, 1'b1, 0, ab);
        respond(3);

`ifdef ARGMAX_FEEDER_TIMEOUT_EN
        // 6: no result arrives, watchdog must fire
        begin
            int n;
            logic [OB-1:0] saved_max;
            logic [IB-1:0] saved_idx;
            saved_max = result_max;
            saved_idx = result_index;
            write_random(N);
            start_pulse();
            play(1'b0, 1'b0, 0, ab);
            n = 0;
            while (n < 100 && timeout_err !== 1'b1) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_tmo_cycle", n, 64);
            chk("t6_done", done, 0);
            chk("t6_busy", busy, 0);
            chk("t6_rmax", result_max, saved_max);
            chk("t6_ridx", result_index, saved_idx);
            chk("t6_wr_full", wr_full, 0);
            @(posedge clk); #1;
            chk("t6_tmo_clear", timeout_err, 0);
            clear_model();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
